candidate_row_assembler: RTL and testbench

CANDIDATE_ROW_ASSEMBLER -- requirements
Module: candidate_row_assembler

---
 rtl/candidate_row_assembler.sv | 137 +++++++++++++
 tb/tb_candidate_row_assembler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/candidate_row_assembler.sv
// ============================================================================
// candidate_row_assembler: packs index tuples into a J-slot candidate row.
// Optional row counter via `CAND_ROW_COUNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module candidate_row_assembler #(
  parameter int J = 14,
  parameter int A = 4,
  localparam int J_WIDTH = $clog2(J) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               index_in_tvalid,
  output logic               index_in_tready,
  input  logic [J_WIDTH-1:0] col_idx1,
  input  logic [J_WIDTH-1:0] col_idx2,
  input  logic [J_WIDTH-1:0] row_idx,
  input  logic               index_in_tlast,
  output logic [J*64-1:0]    candidate_row,
  output logic               candidate_row_tvalid,
  input  logic               candidate_row_tready,
  output logic               candidate_row_tlast,
  output logic               range_err
`ifdef CAND_ROW_COUNT_EN
  ,
  output logic [15:0]        row_count
`endif
);

  localparam logic [J_WIDTH-1:0] LAST_POS = J_WIDTH'(J - 1);
  localparam logic [J_WIDTH-1:0] J_LIM    = J_WIDTH'(J);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [J_WIDTH-1:0] pos_q;
  logic [63:0]        slot_q [J];
  logic               tlast_q;
  logic               err_q;
  logic               tuple_acc;
  logic               row_acc;
  logic               row_done;
  logic               idx_bad;
  logic [63:0]        entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    index_in_tready = 1'b0;
    tuple_acc       = 1'b0;
    row_acc         = 1'b0;
    row_done        = 1'b0;
    case (state_q)
      FILL: begin
        index_in_tready = !rst;
        tuple_acc       = index_in_tvalid && !rst;
        row_done        = tuple_acc && ((pos_q == LAST_POS) || index_in_tlast);
        if (row_done) state_d = HOLD;
      end
      HOLD: begin
        row_acc = candidate_row_tready && !rst;
        if (candidate_row_tready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Fields sit at fixed byte offsets so downstream decode is independent of J.
  always_comb begin
    entry                  = '0;
    entry[0 +: J_WIDTH]    = col_idx1;
    entry[8 +: J_WIDTH]    = col_idx2;
    entry[16 +: J_WIDTH]   = row_idx;
    entry[63]              = 1'b1;
  end

  assign idx_bad = (col_idx1 >= J_LIM) || (col_idx2 >= J_LIM) || (row_idx >= J_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      tlast_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < J; k++) slot_q[k] <= '0;
    end else begin
      if (tuple_acc) begin
        for (int k = 0; k < J; k++) begin
          if (pos_q == J_WIDTH'(k)) slot_q[k] <= entry;
        end
        pos_q <= pos_q + 1'b1;
        if (idx_bad) err_q <= 1'b1;
        if (row_done) tlast_q <= index_in_tlast;
      end
      if (row_acc) begin
        pos_q   <= '0;
        tlast_q <= 1'b0;
        for (int k = 0; k < J; k++) slot_q[k] <= '0;
      end
    end
  end

  for (genvar k = 0; k < J; k++) begin : g_slot
    assign candidate_row[64*k +: 64] = slot_q[k];
  end

  assign candidate_row_tvalid = (state_q == HOLD);
  assign candidate_row_tlast  = tlast_q;
  assign range_err            = err_q;

`ifdef CAND_ROW_COUNT_EN
  logic [15:0] row_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_count_q <= '0;
    end else if (row_acc) begin
      row_count_q <= row_count_q + 16'd1;
    end
  end

  assign row_count = row_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_candidate_row_assembler.sv
// ============================================================================
// tb_candidate_row_assembler: directed and random checks against a queue model.
// ============================================================================
`default_nettype none

module tb_candidate_row_assembler;

  localparam int J  = 14;
  localparam int JW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            vin;
  logic            tready;
  logic [JW-1:0]   c1, c2, ri;
  logic            last;
  logic [J*64-1:0] cand_row;
  logic            tvalid;
  logic            crdy;
  logic            tlast;
  logic            err;
`ifdef CAND_ROW_COUNT_EN
  logic [15:0]     row_count;
`endif

  always #5 clk = ~clk;

  candidate_row_assembler #(.J(J), .A(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .index_in_tvalid      (vin),
    .index_in_tready      (tready),
    .col_idx1             (c1),
    .col_idx2             (c2),
    .row_idx              (ri),
    .index_in_tlast       (last),
    .candidate_row        (cand_row),
    .candidate_row_tvalid (tvalid),
    .candidate_row_tready (crdy),
    .candidate_row_tlast  (tlast),
    .range_err            (err)
`ifdef CAND_ROW_COUNT_EN
    ,
    .row_count            (row_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the current row is just a list of stored entries.
  logic [63:0] mq[$];
  bit          m_hold;
  bit          m_tlast;
  bit          m_err;
  int          m_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance it.
  task automatic tick(input bit r, input bit v, input logic [JW-1:0] a,
                      input logic [JW-1:0] b, input logic [JW-1:0] c,
                      input bit l, input bit rd, output bit acc);
    logic [63:0] e;
    @(negedge clk);
    rst = r; vin = v; c1 = a; c2 = b; ri = c; last = l; crdy = rd;
    #1;
    check("tready", 64'(tready), 64'(!m_hold && !r));
    check("tvalid", 64'(tvalid), 64'(m_hold));
    if (m_hold) check("tlast", 64'(tlast), 64'(m_tlast));
    check("range_err", 64'(err), 64'(m_err));
    for (int k = 0; k < J; k++)
      check($sformatf("slot%0d", k), cand_row[64*k +: 64], (k < mq.size()) ? mq[k] : 64'd0);
`ifdef CAND_ROW_COUNT_EN
    check("row_count", 64'(row_count), 64'(m_count % 65536));
`endif
    acc = 1'b0;
    if (r) begin
      mq.delete(); m_hold = 0; m_tlast = 0; m_err = 0; m_count = 0;
    end else if (!m_hold) begin
      if (v) begin
        acc = 1'b1;
        e = (64'd1 << 63) | (64'(c) << 16) | (64'(b) << 8) | 64'(a);
        mq.push_back(e);
        if (a >= J || b >= J || c >= J) m_err = 1;
        if (mq.size() == J || l) begin
          m_hold  = 1;
          m_tlast = l;
        end
      end
    end else if (rd) begin
      mq.delete(); m_hold = 0; m_count++;
    end
  endtask

  bit          acc;
  bit          pend;
  logic [JW-1:0] pa, pb, pc;
  bit          pl;

  initial begin
    rst = 1; vin = 0; c1 = '0; c2 = '0; ri = '0; last = 0; crdy = 0;
    m_hold = 0; m_tlast = 0; m_err = 0; m_count = 0;
    repeat (2) @(posedge clk);
    tick(1, 0, 0, 0, 0, 0, 0, acc);

    // Full row of 14 tuples, tlast on the 14th.
    for (int k = 0; k < J; k++)
      tick(0, 1, JW'(k), JW'((k + 1) % J), 3, k == J - 1, 1, acc);
    // Held for 5 cycles with upstream still offering a tuple.
    for (int n = 0; n < 5; n++) begin
      tick(0, 1, 1, 2, 3, 0, 0, acc);
      check("hold_slot0", cand_row[63:0], 64'h8000_0000_0003_0100);
      check("hold_slot13", cand_row[64*13 +: 64], 64'h8000_0000_0003_000d);
    end
    tick(0, 1, 1, 2, 3, 0, 1, acc);
    tick(0, 0, 0, 0, 0, 0, 1, acc);

    // Short row: 7 tuples, tlast on the 7th.
    for (int k = 0; k < 7; k++)
      tick(0, 1, JW'(k), JW'(13 - k), JW'(k + 2), k == 6, 0, acc);
    tick(0, 0, 0, 0, 0, 0, 0, acc);
    tick(0, 0, 0, 0, 0, 0, 1, acc);

    // Out-of-range index sets the sticky error.
    tick(0, 1, 2, 3, 15, 1, 1, acc);
    for (int k = 0; k < 20; k++)
      tick(0, 1, JW'(k % J), 1, 2, k == 9, 1, acc);

    // Reset mid-fill discards the partial row.
    for (int k = 0; k < 5; k++)
      tick(0, 1, 9, 9, 9, 0, 1, acc);
    tick(1, 1, 9, 9, 9, 0, 1, acc);
    for (int k = 0; k < J; k++)
      tick(0, 1, JW'(k), 4, 5, 0, 0, acc);
    tick(0, 0, 0, 0, 0, 0, 0, acc);
    tick(0, 0, 0, 0, 0, 0, 1, acc);

    // Random traffic with an upstream that holds a tuple until taken.
    pend = 0; pa = '0; pb = '0; pc = '0; pl = 0;
    for (int n = 0; n < 2500; n++) begin
      if (!pend && ($urandom % 4 != 0)) begin
        pend = 1;
        if ($urandom % 20 == 0) begin
          pa = JW'($urandom_range(0, 31)); pb = JW'($urandom_range(0, 31)); pc = JW'($urandom_range(0, 31));
        end else begin
          pa = JW'($urandom_range(0, J - 1)); pb = JW'($urandom_range(0, J - 1)); pc = JW'($urandom_range(0, J - 1));
        end
        pl = ($urandom % 8 == 0);
      end
      tick($urandom % 300 == 0, pend, pa, pb, pc, pl, $urandom % 3 != 0, acc);
      if (acc) pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
